// File: rtl/ultrasonic_echo_timer_if.sv
// Ultrasonic echo timer bus.
// Groups the sensor-side and result-side signals of one ranging channel.
//   start     : request a ranging cycle (master -> timer)
//   echo      : raw, asynchronous sensor echo (master -> timer)
//   trigger   : sensor trigger pulse (timer -> master)
//   count     : echo width in round-trip units, held between updates
//   calculate : 1-cycle strobe, count updated and valid
//   timeout   : 1-cycle strobe, no echo or echo too long
//   busy      : timer is not idle
interface ultrasonic_echo_timer_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               start;
  logic               echo;
  logic               trigger;
  logic [COUNT_W-1:0] count;
  logic               calculate;
  logic               timeout;
  logic               busy;

  modport master (
    output start, echo,
    input  trigger, count, calculate, timeout, busy
  );

  modport slave (
    input  start, echo,
    output trigger, count, calculate, timeout, busy
  );
endinterface

// File: rtl/ultrasonic_echo_timer.sv
// Ultrasonic echo timer.
// Runs an HC-SR04-style ranging cycle: trigger pulse, wait for echo rise,
// time the echo high width in UNIT_US units (count>>1 = cm), report either
// a valid count (calculate) or a timeout, then hold off before the next cycle.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : ultrasonic_echo_timer_if slave (start, echo in; trigger, count,
//           calculate, timeout, busy out)
module ultrasonic_echo_timer #(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned UNIT_US     = 29,
  parameter int unsigned WAIT_US     = 25000,
  parameter int unsigned MAX_ECHO_US = 38000,
  parameter int unsigned HOLDOFF_US  = 60000,
  parameter int unsigned COUNT_W     = 8
) (
  input logic                    clk,
  input logic                    reset,
  ultrasonic_echo_timer_if.slave bus
);

  localparam int unsigned US_LIM_A = (TRIG_US > WAIT_US) ? TRIG_US : WAIT_US;
  localparam int unsigned US_LIM_B = (MAX_ECHO_US > HOLDOFF_US) ? MAX_ECHO_US : HOLDOFF_US;
  localparam int unsigned US_LIM   = (US_LIM_A > US_LIM_B) ? US_LIM_A : US_LIM_B;
  localparam int unsigned US_W     = $clog2(US_LIM + 1);
  localparam int unsigned PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SUB_W    = (UNIT_US > 1) ? $clog2(UNIT_US) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(UNIT_US - 1);
  localparam logic [US_W-1:0]  TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]  WAIT_LAST = US_W'(WAIT_US - 1);
  localparam logic [US_W-1:0]  ECHO_LAST = US_W'(MAX_ECHO_US - 1);
  localparam logic [US_W-1:0]  HOLD_LAST = US_W'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEASURE,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PRE_W-1:0]   r_pre;
  logic [US_W-1:0]    r_us;
  logic [SUB_W-1:0]   r_sub;
  logic [COUNT_W:0]   r_unit;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_echo_d;
  logic [COUNT_W-1:0] r_count;
  logic               r_calc;
  logic               r_tmo;

  logic               w_tick;
  logic               w_enter;
  logic               w_echo_rise;
  logic               w_echo_fall;
  logic               w_unit_done;
  logic [COUNT_W:0]   w_unit_next;
  logic [COUNT_W-1:0] w_count_sat;
  logic               w_set_calc;
  logic               w_set_tmo;

  assign w_tick      = (r_pre == PRE_LAST);
  assign w_enter     = (w_state_next != r_state);
  assign w_echo_rise = r_sync2 & ~r_echo_d;
  assign w_echo_fall = ~r_sync2 & r_echo_d;
  assign w_unit_done = w_tick && (r_sub == SUB_LAST);

  // The unit counter carries one extra bit; once it reaches 2^COUNT_W it
  // stops, and anything with the top bit set reads back as all ones.
  // The captured value includes a unit completing on the capture edge.
  assign w_unit_next = (w_unit_done && !r_unit[COUNT_W]) ? r_unit + 1'b1 : r_unit;
  assign w_count_sat = w_unit_next[COUNT_W] ? '1 : w_unit_next[COUNT_W-1:0];

  // Echo synchroniser plus a delayed copy for edge detection. The edge
  // flop follows the synchronised echo in every state, so an echo that is
  // already high when WAIT is entered is not seen as a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      r_sync1  <= bus.echo;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_set_calc   = 1'b0;
    w_set_tmo    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_TRIG;
      end
      S_TRIG: begin
        if (w_tick && (r_us == TRIG_LAST)) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_echo_rise) begin
          w_state_next = S_MEASURE;
        end else if (w_tick && (r_us == WAIT_LAST)) begin
          w_state_next = S_HOLD;
          w_set_tmo    = 1'b1;
        end
      end
      S_MEASURE: begin
        if (w_echo_fall) begin
          w_state_next = S_HOLD;
          w_set_calc   = 1'b1;
        end else if (w_tick && (r_us == ECHO_LAST)) begin
          w_state_next = S_HOLD;
          w_set_tmo    = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_tick && (r_us == HOLD_LAST)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic. trigger and busy decode the state register directly so
  // they fall together with the asynchronous reset.
  always_comb begin
    bus.trigger   = (r_state == S_TRIG);
    bus.busy      = (r_state != S_IDLE);
    bus.count     = r_count;
    bus.calculate = r_calc;
    bus.timeout   = r_tmo;
  end

  // Microsecond time base: prescaler, us-in-state counter and the us
  // position within the current echo unit. All restart on state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_us  <= '0;
      r_sub <= '0;
    end else if (w_enter) begin
      r_pre <= '0;
      r_us  <= '0;
      r_sub <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_us  <= r_us + 1'b1;
      r_sub <= (r_sub == SUB_LAST) ? '0 : r_sub + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_unit <= '0;
    else if (w_enter)                r_unit <= '0;
    else if (r_state == S_MEASURE)   r_unit <= w_unit_next;
  end

  // Result register and strobes; count and calculate update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_calc  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_calc <= w_set_calc;
      r_tmo  <= w_set_tmo;
      if (w_set_calc) r_count <= w_count_sat;
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_timer.sv
// Self-checking bench for ultrasonic_echo_timer with reduced timing
// parameters (CLK_DIV=2, WAIT_US=1000, MAX_ECHO_US=10000, HOLDOFF_US=100).
module tb_ultrasonic_echo_timer;

  localparam int unsigned COUNT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  ultrasonic_echo_timer_if #(.COUNT_W(COUNT_W)) bus ();

  ultrasonic_echo_timer #(
    .CLK_DIV    (2),
    .TRIG_US    (10),
    .UNIT_US    (29),
    .WAIT_US    (1000),
    .MAX_ECHO_US(10000),
    .HOLDOFF_US (100),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Strobe monitor; only read back at quiet points well away from strobes.
  int calc_n = 0;
  int tmo_n  = 0;
  int both_n = 0;
  int busy_low = 0;

  always @(negedge clk) begin
    if (reset) begin
      calc_n = calc_n + int'(bus.calculate);
      tmo_n  = tmo_n  + int'(bus.timeout);
      both_n = both_n + int'(bus.calculate & bus.timeout);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.trigger;
      1:       return bus.calculate;
      2:       return bus.timeout;
      default: return bus.busy;
    endcase
  endfunction

  // Advance negedges until the selected output equals val, bounded.
  task automatic wait_for(input string tag, input int sel, input logic val,
                          input int max_cyc, output int n);
    n = 0;
    while (sig(sel) !== val && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sig(sel)), 32'(val));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_low++;
    end
  endtask

  // One-cycle start pulse; returns trigger width, ending on the first
  // negedge with trigger low (WAIT entered on the preceding posedge).
  task automatic run_start(output int tw);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tw = 0;
    while (bus.trigger === 1'b1 && tw < 1000) begin
      if (bus.busy !== 1'b1) busy_low++;
      tw++;
      @(negedge clk);
    end
  endtask

  int n, tw, c0, t0, trig_seen;

  initial begin
    bus.start = 1'b0;
    bus.echo  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_trigger", 32'(bus.trigger), 0);
    chk("rst_count",   32'(bus.count), 0);
    chk("rst_calc",    32'(bus.calculate), 0);
    chk("rst_tmo",     32'(bus.timeout), 0);
    chk("rst_busy",    32'(bus.busy), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1. Nominal: 590 us echo -> 20 units
    c0 = calc_n; t0 = tmo_n; busy_low = 0;
    run_start(tw);
    chk("nom_trig_width", 32'(tw), 20);
    step(100);
    bus.echo = 1'b1;
    step(1180);
    bus.echo = 1'b0;
    wait_for("nom_calc", 1, 1'b1, 10, n);
    chk("nom_count", 32'(bus.count), 20);
    chk("nom_busy", 32'(busy_low), 0);
    wait_for("nom_idle", 3, 1'b0, 400, n);
    chk("nom_hold_len", 32'(n), 200);
    chk("nom_calc_pulses", 32'(calc_n - c0), 1);
    chk("nom_tmo_pulses", 32'(tmo_n - t0), 0);

    // 2. No echo: timeout 2000 clk after trigger falls
    c0 = calc_n; t0 = tmo_n;
    run_start(tw);
    wait_for("noecho_tmo", 2, 1'b1, 2100, n);
    chk("noecho_delay", 32'(n), 2000);
    chk("noecho_count", 32'(bus.count), 20);
    wait_for("noecho_idle", 3, 1'b0, 400, n);
    chk("noecho_calc_pulses", 32'(calc_n - c0), 0);
    chk("noecho_tmo_pulses", 32'(tmo_n - t0), 1);

    // 3. Saturation: 8000 us = 275 units, clamps to 255
    c0 = calc_n; t0 = tmo_n;
    run_start(tw);
    step(10);
    bus.echo = 1'b1;
    step(16000);
    bus.echo = 1'b0;
    wait_for("sat_calc", 1, 1'b1, 10, n);
    chk("sat_count", 32'(bus.count), 255);
    wait_for("sat_idle", 3, 1'b0, 400, n);
    chk("sat_calc_pulses", 32'(calc_n - c0), 1);
    chk("sat_tmo_pulses", 32'(tmo_n - t0), 0);

    // 4. Stuck echo: MEASURE is entered on the third posedge after the raw
    // rise (two sync flops, then the state change), and lasts 20000 clk.
    c0 = calc_n; t0 = tmo_n;
    run_start(tw);
    step(10);
    bus.echo = 1'b1;
    wait_for("stuck_tmo", 2, 1'b1, 21000, n);
    chk("stuck_delay", 32'(n), 20003);
    chk("stuck_count", 32'(bus.count), 255);
    bus.echo = 1'b0;
    wait_for("stuck_idle", 3, 1'b0, 400, n);
    chk("stuck_calc_pulses", 32'(calc_n - c0), 0);
    chk("stuck_tmo_pulses", 32'(tmo_n - t0), 1);

    // 5. Reset during TRIG, then during MEASURE, taken between clock edges
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rtrig_pre_trigger", 32'(bus.trigger), 1);
    #2 reset = 1'b0;
    #1;
    chk("rtrig_trigger", 32'(bus.trigger), 0);
    chk("rtrig_count", 32'(bus.count), 0);
    chk("rtrig_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_start(tw);
    step(10);
    bus.echo = 1'b1;
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rmeas_trigger", 32'(bus.trigger), 0);
    chk("rmeas_busy", 32'(bus.busy), 0);
    chk("rmeas_calc", 32'(bus.calculate), 0);
    bus.echo = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Clean cycle after reset: 58 us echo -> 2 units
    run_start(tw);
    chk("clean_trig_width", 32'(tw), 20);
    step(10);
    bus.echo = 1'b1;
    step(116);
    bus.echo = 1'b0;
    wait_for("clean_calc", 1, 1'b1, 10, n);
    chk("clean_count", 32'(bus.count), 2);
    wait_for("clean_idle", 3, 1'b0, 400, n);

    // 6a. Start pulses during MEASURE and HOLD are dropped
    run_start(tw);
    step(10);
    bus.echo = 1'b1;
    step(200);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    step(99);
    bus.echo = 1'b0;
    wait_for("ign_calc", 1, 1'b1, 10, n);
    chk("ign_count", 32'(bus.count), 5);
    repeat (50) @(negedge clk);
    chk("ign_in_hold", 32'(bus.busy), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_for("ign_idle", 3, 1'b0, 400, n);
    trig_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.trigger !== 1'b0 || bus.busy !== 1'b0) trig_seen++;
    end
    chk("ign_no_restart", 32'(trig_seen), 0);

    // 6b. start held high: new trigger one cycle after each HOLD exit
    bus.start = 1'b1;
    wait_for("held_trig1", 0, 1'b1, 5, n);
    wait_for("held_tmo1", 2, 1'b1, 2100, n);
    wait_for("held_idle1", 3, 1'b0, 400, n);
    chk("held_hold_len", 32'(n), 200);
    chk("held_idle_trigger", 32'(bus.trigger), 0);
    @(negedge clk);
    chk("held_retrigger", 32'(bus.trigger), 1);
    bus.start = 1'b0;
    wait_for("held_tmo2", 2, 1'b1, 2100, n);
    wait_for("held_idle2", 3, 1'b0, 400, n);

    chk("strobes_exclusive", 32'(both_n), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
